rr_burst_arbiter: RTL and testbench
===================================

RR_BURST_ARBITER -- requirements
Module: rr_burst_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive grant cycles per owner while another requester waits (legal range 1..7).
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Ports req_0, req_1, req_2, req_3, input, 1 bit each: request from requester n, level-sensitive.
REQ-005 Ports gnt_0, gnt_1, gnt_2, gnt_3, output, 1 bit each: registered grant to requester n.
REQ-006 Port gnt_valid, output, 1 bit: registered; high when any gnt_n is high.
REQ-007 Port gnt_id, output, 2 bits: registered index of the current owner; holds its last value when gnt_valid is low.

Function
REQ-008 {gnt_3..gnt_0} SHALL always be one-hot or all zero.
REQ-009 The block SHALL implement two states: IDLE (no owner) and GRANT (one owner).
REQ-010 The block SHALL keep a 2-bit last-winner pointer LAST and a 3-bit burst counter CNT.
REQ-011 Winner selection SHALL be round-robin: search indices LAST+1, LAST+2, LAST+3, LAST (mod 4) and pick the first with req high.
REQ-012 In IDLE with any req high at a clock edge, the block SHALL enter GRANT with gnt_n of the winner high from that edge; latency is 1 cycle from req sampled to gnt visible.
REQ-013 Every new grant SHALL set LAST to the winner, gnt_id to the winner, and CNT to 1.
REQ-014 In GRANT with the owner's req high and no other req high, the owner SHALL keep its grant; CNT SHALL increment and saturate at MAX_BURST.
REQ-015 In GRANT with the owner's req high, another req high, and CNT < MAX_BURST, the owner SHALL keep its grant and CNT SHALL increment.
REQ-016 In GRANT with the owner's req high, another req high, and CNT == MAX_BURST, the grant SHALL pass at that edge to the round-robin winner excluding the owner, with no idle cycle.
REQ-017 In GRANT with the owner's req low and another req high, the grant SHALL pass at that edge to the round-robin winner, with no idle cycle.
REQ-018 In GRANT with all req low, the block SHALL return to IDLE; all gnt_n and gnt_valid SHALL go low at that edge.
REQ-019 Grant removal SHALL occur only at the clock edge that samples the owner's req low; the owner holds its grant for the whole cycle in which it drops req.
REQ-020 A requester that deasserts req before being granted SHALL NOT be granted and SHALL NOT affect LAST.
REQ-021 With MAX_BURST = 1, the grant SHALL rotate every cycle whenever two or more requesters are active.

Reset
REQ-022 While reset is high, gnt_0..gnt_3 SHALL be 0, gnt_valid 0, gnt_id 0, state IDLE, CNT 0, and LAST 3, so requester 0 has first priority after reset.
REQ-023 Assertion of reset SHALL clear all outputs immediately, without waiting for a clock edge, including mid-burst.
REQ-024 The first grant after reset release SHALL be decided at the first rising edge at which reset is low.

Verification
REQ-025 Reset release; req = 4'b1111 held, MAX_BURST = 4 -> gnt_0 for 4 cycles, then gnt_1 for 4, gnt_2 for 4, gnt_3 for 4, then gnt_0; no gap cycles.
REQ-026 Only req_2 held for 10 cycles -> gnt_2 continuous from cycle 1 to cycle 10; CNT saturates at 4; gnt_id = 2.
REQ-027 gnt_1 owner with req_3 pending; req_1 drops at CNT = 2 -> next edge gnt_3 high, gnt_1 low, gnt_id = 3.
REQ-028 All req drop while gnt_0 is held -> next edge gnt_valid = 0 and gnt = 0000; gnt_id stays 0; a subsequent req = 4'b0011 -> gnt_1 (LAST = 0).
REQ-029 reset asserted mid-burst between clock edges -> all grants 0 immediately; after release with req = 4'b1000 -> gnt_3 one cycle later.
REQ-030 Random req for 1000 cycles, checked every cycle: one-hot-or-zero grants; every continuously-held request granted within 3*MAX_BURST+1 cycles; gnt_valid equal to the OR of gnt_0..gnt_3.

Source files
------------

// File: rtl/rr_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_burst_arbiter
// Brief    : Four-requester round-robin arbiter with registered one-hot
//            grants and a per-owner burst limit that applies only while
//            another requester is waiting.
// Revision : 1.0 - initial release
// ============================================================================
module rr_burst_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_0,
    input  logic       req_1,
    input  logic       req_2,
    input  logic       req_3,
    output logic       gnt_0,
    output logic       gnt_1,
    output logic       gnt_2,
    output logic       gnt_3,
    output logic       gnt_valid,
    output logic [1:0] gnt_id
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_GRANT = 1'b1;
    localparam logic [2:0] c_MAX   = 3'(MAX_BURST);

    // Round-robin search starting one past 'last'; returns {found, index}.
    // Iterating from the farthest candidate down lets the nearest one win.
    function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    logic [0:0] r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_gnt_id;
    logic       r_valid;
    logic [1:0] r_last;
    logic [2:0] r_cnt;

    logic [0:0] w_nxt_state;
    logic [3:0] w_nxt_gnt;
    logic [1:0] w_nxt_id;
    logic [1:0] w_nxt_last;
    logic [2:0] w_nxt_cnt;

    logic [3:0] w_req;
    logic       w_owner_req;
    logic       w_other_req;
    logic [2:0] w_pick;
    logic       w_pick_valid;
    logic [1:0] w_pick_idx;

    assign w_req       = {req_3, req_2, req_1, req_0};
    assign w_owner_req = |(w_req & r_gnt);
    assign w_other_req = |(w_req & ~r_gnt);

    // Masking out the owner makes one search serve both cases: in IDLE the
    // mask is empty, and in GRANT the owner equals LAST so it is excluded.
    assign w_pick       = rr_pick(w_req & ~r_gnt, r_last);
    assign w_pick_valid = w_pick[2];
    assign w_pick_idx   = w_pick[1:0];

    // Next-state decision: keep, hand over, or release the grant.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_gnt   = r_gnt;
        w_nxt_id    = r_gnt_id;
        w_nxt_last  = r_last;
        w_nxt_cnt   = r_cnt;
        if (r_state == c_GRANT && w_owner_req && (!w_other_req || r_cnt < c_MAX)) begin
            // Owner keeps the grant; counter saturates when unopposed.
            if (r_cnt < c_MAX) begin
                w_nxt_cnt = r_cnt + 3'd1;
            end
        end else if (w_pick_valid) begin
            // New grant: from IDLE, or a hand-over with no idle cycle.
            w_nxt_state = c_GRANT;
            w_nxt_gnt   = 4'(1 << w_pick_idx);
            w_nxt_id    = w_pick_idx;
            w_nxt_last  = w_pick_idx;
            w_nxt_cnt   = 3'd1;
        end else begin
            // Nobody requesting: drop to IDLE, gnt_id keeps its last value.
            w_nxt_state = c_IDLE;
            w_nxt_gnt   = 4'b0000;
            w_nxt_cnt   = 3'd0;
        end
    end

    // State registers; LAST resets to 3 so requester 0 is first in line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_gnt    <= 4'b0000;
            r_gnt_id <= 2'd0;
            r_valid  <= 1'b0;
            r_last   <= 2'd3;
            r_cnt    <= 3'd0;
        end else begin
            r_state  <= w_nxt_state;
            r_gnt    <= w_nxt_gnt;
            r_gnt_id <= w_nxt_id;
            r_valid  <= |w_nxt_gnt;
            r_last   <= w_nxt_last;
            r_cnt    <= w_nxt_cnt;
        end
    end

    assign gnt_0     = r_gnt[0];
    assign gnt_1     = r_gnt[1];
    assign gnt_2     = r_gnt[2];
    assign gnt_3     = r_gnt[3];
    assign gnt_valid = r_valid;
    assign gnt_id    = r_gnt_id;

endmodule
`default_nettype wire

// File: tb/tb_rr_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_burst_arbiter
// Brief    : Scoreboard bench for rr_burst_arbiter: directed vectors push
//            expected grants, a monitor pops and compares after each edge;
//            a random phase checks grant invariants and fairness.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_burst_arbiter;

    localparam int MB    = 4;
    localparam int LIMIT = 3 * MB + 1;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       gnt_0, gnt_1, gnt_2, gnt_3, gnt_valid;
    logic [1:0] gnt_id;
    logic [3:0] gw;

    int total = 0;
    int bad   = 0;

    logic [6:0] exp_q[$];
    string      name_q[$];

    assign gw = {gnt_3, gnt_2, gnt_1, gnt_0};

    rr_burst_arbiter #(.MAX_BURST(MB)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_0    (req[0]),
        .req_1    (req[1]),
        .req_2    (req[2]),
        .req_3    (req[3]),
        .gnt_0    (gnt_0),
        .gnt_1    (gnt_1),
        .gnt_2    (gnt_2),
        .gnt_3    (gnt_3),
        .gnt_valid(gnt_valid),
        .gnt_id   (gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply a request pattern before the next edge and queue what that edge must produce.
    task automatic drive(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] eid,
                         input logic ev, input string nm);
        @(negedge clk);
        req = r;
        exp_q.push_back({ev, eid, eg});
        name_q.push_back(nm);
    endtask

    // Monitor: after every edge, compare {valid,id,gnt} to the oldest expectation.
    initial begin
        logic [6:0] e;
        string      n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                chk(n, 32'({gnt_valid, gnt_id, gw}), 32'(e));
            end
        end
    end

    initial begin
        int         wt[4];
        int         o;
        logic [3:0] g;

        reset = 1'b1;
        req   = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({gnt_valid, gnt_id, gw}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // All four requesting: bursts of MB grants in order 0,1,2,3,0.
        for (int k = 0; k < 17; k++) begin
            o = (k / 4) % 4;
            g = 4'(1 << o);
            drive(4'b1111, g, 2'(o), 1'b1, "rotate_all");
        end
        drive(4'b0000, 4'b0000, 2'd0, 1'b0, "all_drop_idle");
        drive(4'b0011, 4'b0010, 2'd1, 1'b1, "after_drop_last0");
        drive(4'b1010, 4'b0010, 2'd1, 1'b1, "owner_hold_cnt2");
        drive(4'b1000, 4'b1000, 2'd3, 1'b1, "owner_drop_pass");
        drive(4'b0000, 4'b0000, 2'd3, 1'b0, "idle_id_hold");

        // Lone requester keeps the grant and the counter saturates.
        for (int k = 0; k < 10; k++) begin
            drive(4'b0100, 4'b0100, 2'd2, 1'b1, "solo_req2");
        end
        drive(4'b0101, 4'b0001, 2'd0, 1'b1, "saturated_pass");
        drive(4'b0000, 4'b0000, 2'd0, 1'b0, "idle_2");

        // Withdrawn request never granted and must not move LAST.
        drive(4'b0001, 4'b0001, 2'd0, 1'b1, "grant0");
        drive(4'b0011, 4'b0001, 2'd0, 1'b1, "grant0_keep");
        drive(4'b0001, 4'b0001, 2'd0, 1'b1, "req1_withdrawn");
        drive(4'b0000, 4'b0000, 2'd0, 1'b0, "idle_3");
        drive(4'b0110, 4'b0010, 2'd1, 1'b1, "last_unaffected");
        drive(4'b1111, 4'b0010, 2'd1, 1'b1, "burst_keep");

        // Asynchronous reset in the middle of a burst.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_clear", 32'({gnt_valid, gnt_id, gw}), 32'd0);
        @(posedge clk);
        #1;
        chk("reset_hold", 32'({gnt_valid, gnt_id, gw}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        req   = 4'b1000;
        exp_q.push_back({1'b1, 2'd3, 4'b1000});
        name_q.push_back("post_reset_req3");
        drive(4'b0000, 4'b0000, 2'd3, 1'b0, "idle_4");
        @(posedge clk);
        #2;

        // Random phase: pending requests stay up until served.
        for (int n = 0; n < 4; n++) wt[n] = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            for (int n = 0; n < 4; n++) begin
                if (!(req[n] && !gw[n])) req[n] = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            chk("onehot0", 32'($onehot0(gw)), 32'd1);
            chk("valid_is_or", 32'(gnt_valid), 32'(|gw));
            if (gnt_valid) chk("id_matches_gnt", 32'(gw[gnt_id]), 32'd1);
            for (int n = 0; n < 4; n++) begin
                if (req[n] && !gw[n]) wt[n]++;
                else wt[n] = 0;
                chk($sformatf("starve_wait_r%0d", n), 32'(wt[n] <= LIMIT), 32'd1);
            end
        end

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
